// File: rtl/expr_feed_ctrl.sv
// Character FIFO plus sequencer that replays a queued expression into an
// external Moore checker and captures its accept flag.
module expr_feed_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic [4:0] count,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic       chk_clr,
    output logic [7:0] chk_in,
    input  logic       chk_out
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        SAMPLE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [4:0]  count_r;
    logic [4:0]  feed_n;
    logic        snap_zero;
    logic        push_ok;
    logic        pop;

    assign full    = (count_r == DEPTH_C);
    assign count   = count_r;
    assign push_ok = push && !full;
    assign pop     = (state == FEED);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (feed_n != 5'd0) ? FEED : SAMPLE;
            FEED:    if (feed_n == 5'd1) state_nx = SAMPLE;
            SAMPLE:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        chk_clr = (state == CLEAR);
        chk_in  = 8'h00;
        if (state == FEED) chk_in = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_r   <= 5'd0;
            feed_n    <= 5'd0;
            snap_zero <= 1'b0;
            result    <= 1'b0;
        end else begin
            state <= state_nx;
            // Only characters present at the start edge belong to this expression.
            if (state == IDLE && start) begin
                feed_n    <= count_r;
                snap_zero <= (count_r == 5'd0);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                feed_n <= feed_n - 5'd1;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
            if (state == SAMPLE) result <= snap_zero ? 1'b0 : chk_out;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: doc/expr_feed_ctrl.md
EXPR_FEED_CTRL -- requirements
Module: expr_feed_ctrl

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 8, meaning the character FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port push, input, 1 bit: write push_data into the FIFO this cycle.
REQ-005 The block SHALL have port push_data, input, 8 bits: ASCII character to enqueue.
REQ-006 The block SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-007 The block SHALL have port count, output, 5 bits: current FIFO occupancy.
REQ-008 The block SHALL have port start, input, 1 bit: request evaluation of the queued expression.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-011 The block SHALL have port result, output, 1 bit: 1 = expression accepted; held until the next done.
REQ-012 The block SHALL have port chk_clr, output, 1 bit: drives the clear input of the expression checker.
REQ-013 The block SHALL have port chk_in, output, 8 bits: drives the character input of the checker.
REQ-014 The block SHALL have port chk_out, input, 1 bit: the checker's Moore accept output.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, FEED, SAMPLE and DONE.
REQ-016 IDLE SHALL go to CLEAR on the edge where start=1; in every other state, start SHALL be ignored.
REQ-017 On the start edge, the block SHALL snapshot count into a feed counter N; only those N characters SHALL form the expression.
REQ-018 CLEAR SHALL last exactly one cycle with chk_clr=1, and chk_clr SHALL be 0 in all other states.
REQ-019 CLEAR SHALL go to FEED if N>0, otherwise to SAMPLE.
REQ-020 FEED SHALL last exactly N cycles, with chk_in = FIFO head each cycle.
REQ-021 At each FEED edge, the block SHALL pop the head and decrement N; when N reaches 0, the state SHALL go to SAMPLE.
REQ-022 SAMPLE SHALL last one cycle with chk_in=8'h00, and at its closing edge the block SHALL register result = chk_out, or 0 if the snapshot N was 0.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Latency: with the start edge at cycle 0, CLEAR SHALL be in cycle 1, FEED in cycles 2..N+1, SAMPLE in cycle N+2, and done=1 in cycle N+3.
REQ-025 chk_in SHALL be 8'h00 outside FEED.
REQ-026 A push while full=1 SHALL be dropped, with no state change.
REQ-027 A push during FEED with full=0 SHALL be accepted, including a push in the same cycle as a pop, and count SHALL be unchanged on a simultaneous push and pop.
REQ-028 Characters pushed after the start snapshot SHALL remain queued for the next evaluation.
REQ-029 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-030 count SHALL range 0..DEPTH, and full SHALL equal (count==DEPTH).
REQ-031 The block SHALL NOT interpret characters; validity is decided solely by chk_out.

Reset
REQ-032 When clr=1 at an edge, the FSM SHALL go to IDLE, the FIFO SHALL be emptied (count=0, full=0), and result, done and chk_clr SHALL be 0, with chk_in=8'h00 and busy=0.
REQ-033 Reset mid-operation (any state) SHALL abort the evaluation, with no done pulse and all queued characters discarded.
REQ-034 push and start SHALL be ignored at an edge where clr=1.

Verification
REQ-035 The bench SHALL cover: push "1","+","2", start at cycle 0 -> chk_clr=1 in cycle 1, chk_in="1","+","2" in cycles 2-4, done=1 in cycle 6, result=1 (with a reference checker).
REQ-036 The bench SHALL cover: push "1","+","+","2", start -> done in cycle 7, result=0; a follow-up "1","*","3","+","5" -> done in cycle 8, result=1.
REQ-037 The bench SHALL cover: start with empty FIFO -> CLEAR then SAMPLE, no FEED cycle, done in cycle 3, result=0.
REQ-038 The bench SHALL cover: 9 pushes with DEPTH=8 -> full=1 after the 8th, 9th dropped, count=8; start -> exactly 8 chars fed, done in cycle 11.
REQ-039 The bench SHALL cover: push "1","2", start, then push "+" in cycle 2 -> chk_in shows only "1","2", "+" remains with count=1 after done, result=0 for "12".
REQ-040 The bench SHALL cover: clr=1 during cycle 3 of FEED -> next cycle busy=0, count=0, chk_in=8'h00, no done pulse ever asserted for that start.
